// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package ss_pkg;

  typedef logic [2:0] slot_t;

  typedef struct packed {
    logic       valid;
    logic       dp;
    logic [3:0] digit;
  } entry_t;

  // Round-robin owner: which requester wins the next contended cycle.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high segments: bit0 top ... bit6 middle, indexed by hex digit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/ss_scan_scheduler_if.sv
// Digit write request channel: valid/ready handshake carrying slot, digit and dp.
interface ss_scan_scheduler_if;
  import ss_pkg::*;

  logic       valid;
  slot_t      idx;
  logic [3:0] digit;
  logic       dp;
  logic       ready;

  modport master (output valid, idx, digit, dp, input ready);
  modport slave  (input valid, idx, digit, dp, output ready);

endinterface

// File: rtl/hex_seg_decode.sv
// Combinational hex digit to 7-segment pattern (no decimal point).
module hex_seg_decode
  import ss_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

// File: rtl/ss_scan_scheduler.sv
// Eight-slot digit buffer with two round-robin writers, scanned through one
// shared hex decoder into registered per-slot display patterns.
module ss_scan_scheduler
  import ss_pkg::*;
#(
  parameter int SCAN_DIV  = 1,
  parameter int NUM_SLOTS = 8
) (
  input  logic                  hz100,
  input  logic                  reset,
  ss_scan_scheduler_if.slave    a,
  ss_scan_scheduler_if.slave    b,
  input  logic                  clr,
  output logic [7:0]            ss0,
  output logic [7:0]            ss1,
  output logic [7:0]            ss2,
  output logic [7:0]            ss3,
  output logic [7:0]            ss4,
  output logic [7:0]            ss5,
  output logic [7:0]            ss6,
  output logic [7:0]            ss7,
  output slot_t                 scan_slot
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  rr_t                          rr_q;
  entry_t                       buf_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0][7:0]    ss_q;
  logic [DIV_W-1:0]             div_q;

  logic   grant_a, grant_b, contended, wr_en, tc;
  slot_t  wr_idx;
  entry_t wr_entry, dec_in;
  logic [6:0] seg;
  logic [7:0] pattern;

  // Arbitration: clr blocks both sides; a lone requester always wins;
  // contention goes to the pointer side.
  always_comb begin
    contended = a.valid && b.valid && !clr;
    grant_a   = !clr && a.valid && (!b.valid || rr_q == RR_A);
    grant_b   = !clr && b.valid && (!a.valid || rr_q == RR_B);
    a.ready   = grant_a;
    b.ready   = grant_b;
  end

  // Write mux: at most one side is granted, so a simple select suffices.
  always_comb begin
    wr_en    = grant_a || grant_b;
    wr_idx   = grant_a ? a.idx : b.idx;
    wr_entry = '{valid: 1'b1,
                 dp:    grant_a ? a.dp    : b.dp,
                 digit: grant_a ? a.digit : b.digit};
  end

  // Pointer flips only after a contended grant so idle cycles keep fairness state.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset)
      rr_q <= RR_A;
    else if (contended)
      rr_q <= (rr_q == RR_A) ? RR_B : RR_A;
  end

  // Digit buffer: clr wins over a write and only drops the valid flags.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) buf_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_SLOTS; i++) buf_q[i].valid <= 1'b0;
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_entry;
    end
  end

  assign tc = (div_q == DIV_W'(SCAN_DIV - 1));

  // Scan divider and slot pointer: dwell SCAN_DIV cycles per slot, wrap 7->0.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      scan_slot <= '0;
    end else if (tc) begin
      div_q     <= '0;
      scan_slot <= scan_slot + slot_t'(1);
    end else begin
      div_q     <= div_q + DIV_W'(1);
    end
  end

  // Decoder sees the registered entry, so a same-cycle write is not visible yet.
  assign dec_in = buf_q[scan_slot];

  hex_seg_decode u_dec (
    .digit (dec_in.digit),
    .seg   (seg)
  );

  assign pattern = dec_in.valid ? {dec_in.dp, seg} : SEG_BLANK;

  // Only the slot being scanned is refreshed, and only at its terminal count.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset)
      ss_q <= '0;
    else if (tc)
      ss_q[scan_slot] <= pattern;
  end

  assign ss0 = ss_q[0];
  assign ss1 = ss_q[1];
  assign ss2 = ss_q[2];
  assign ss3 = ss_q[3];
  assign ss4 = ss_q[4];
  assign ss5 = ss_q[5];
  assign ss6 = ss_q[6];
  assign ss7 = ss_q[7];

endmodule

// File: tb/tb_ss_scan_scheduler.sv
// Directed bench: one instance at SCAN_DIV=1 for handshake/decode behaviour,
// one at SCAN_DIV=3 for divider timing and the same-cycle collision case.
module tb_ss_scan_scheduler;

  logic       hz100 = 1'b0;
  logic       reset = 1'b0;
  logic       rst3  = 1'b0;
  logic       clr   = 1'b0;
  logic       clr3  = 1'b0;
  logic [7:0] ss  [8];
  logic [7:0] s3  [8];
  logic [2:0] scan_slot, scan_slot3;
  int         checks = 0;
  int         errors = 0;

  ss_scan_scheduler_if a_if ();
  ss_scan_scheduler_if b_if ();
  ss_scan_scheduler_if a3_if ();
  ss_scan_scheduler_if b3_if ();

  always #5 hz100 = ~hz100;

  ss_scan_scheduler #(.SCAN_DIV(1), .NUM_SLOTS(8)) dut1 (
    .hz100(hz100), .reset(reset), .a(a_if.slave), .b(b_if.slave), .clr(clr),
    .ss0(ss[0]), .ss1(ss[1]), .ss2(ss[2]), .ss3(ss[3]),
    .ss4(ss[4]), .ss5(ss[5]), .ss6(ss[6]), .ss7(ss[7]),
    .scan_slot(scan_slot)
  );

  ss_scan_scheduler #(.SCAN_DIV(3), .NUM_SLOTS(8)) dut3 (
    .hz100(hz100), .reset(rst3), .a(a3_if.slave), .b(b3_if.slave), .clr(clr3),
    .ss0(s3[0]), .ss1(s3[1]), .ss2(s3[2]), .ss3(s3[3]),
    .ss4(s3[4]), .ss5(s3[5]), .ss6(s3[6]), .ss7(s3[7]),
    .scan_slot(scan_slot3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic [2:0] i, input logic [3:0] d, input logic p);
    a_if.valid = v; a_if.idx = i; a_if.digit = d; a_if.dp = p;
  endtask

  task automatic set_b(input logic v, input logic [2:0] i, input logic [3:0] d, input logic p);
    b_if.valid = v; b_if.idx = i; b_if.digit = d; b_if.dp = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    a3_if.valid = 0; a3_if.idx = 0; a3_if.digit = 0; a3_if.dp = 0;
    b3_if.valid = 0; b3_if.idx = 0; b3_if.digit = 0; b3_if.dp = 0;

    // Reset asserted mid-cycle, before any clock edge.
    #3 reset = 1'b1; rst3 = 1'b1;
    #1;
    chk("rst_scan_slot", {5'd0, scan_slot}, 8'h00);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_ss%0d", i), ss[i], 8'h00);
    chk("rst_a_ready", {7'd0, a_if.ready}, 8'h00);
    chk("rst_b_ready", {7'd0, b_if.ready}, 8'h00);

    @(negedge hz100);
    @(negedge hz100);
    reset = 1'b0;

    // Single write from A: slot 0, digit 5.
    set_a(1, 3'd0, 4'd5, 1'b0);
    #1;
    chk("single_a_ready", {7'd0, a_if.ready}, 8'h01);
    chk("single_b_ready", {7'd0, b_if.ready}, 8'h00);
    @(negedge hz100);
    set_a(0, 0, 0, 0);
    #1;
    chk("single_a_ready_drop", {7'd0, a_if.ready}, 8'h00);
    chk("single_ss0_old", ss[0], 8'h00);
    chk("single_scan_slot", {5'd0, scan_slot}, 8'h01);
    repeat (9) @(negedge hz100);
    chk("single_ss0", ss[0], 8'h6D);
    for (int i = 1; i < 8; i++) chk($sformatf("single_ss%0d", i), ss[i], 8'h00);

    // Fairness: both held valid for 6 cycles from a pointer at A.
    for (int k = 0; k < 6; k++) begin
      @(negedge hz100);
      set_a(1, 3'd3, 4'(k), 1'b0);
      set_b(1, 3'd4, 4'(k + 8), 1'b0);
      #1;
      chk($sformatf("fair_a_ready%0d", k), {7'd0, a_if.ready}, (k % 2 == 0) ? 8'h01 : 8'h00);
      chk($sformatf("fair_b_ready%0d", k), {7'd0, b_if.ready}, (k % 2 == 1) ? 8'h01 : 8'h00);
    end
    @(negedge hz100);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (9) @(negedge hz100);
    chk("fair_ss3", ss[3], 8'h66);
    chk("fair_ss4", ss[4], 8'h5E);

    // Contention: pointer back at A, so A first, then B alone.
    @(negedge hz100);
    set_a(1, 3'd1, 4'd8, 1'b0);
    set_b(1, 3'd2, 4'hF, 1'b0);
    #1;
    chk("cont_a_ready1", {7'd0, a_if.ready}, 8'h01);
    chk("cont_b_ready1", {7'd0, b_if.ready}, 8'h00);
    @(negedge hz100);
    set_a(0, 0, 0, 0);
    #1;
    chk("cont_a_ready2", {7'd0, a_if.ready}, 8'h00);
    chk("cont_b_ready2", {7'd0, b_if.ready}, 8'h01);
    @(negedge hz100);
    set_b(0, 0, 0, 0);
    repeat (9) @(negedge hz100);
    chk("cont_ss1", ss[1], 8'h7F);
    chk("cont_ss2", ss[2], 8'h71);
    chk("cont_ss0", ss[0], 8'h6D);

    // Decimal point on slot 7, then clr against concurrent requests.
    @(negedge hz100);
    set_a(1, 3'd7, 4'd0, 1'b1);
    #1;
    chk("dp_a_ready", {7'd0, a_if.ready}, 8'h01);
    @(negedge hz100);
    set_a(0, 0, 0, 0);
    repeat (9) @(negedge hz100);
    chk("dp_ss7", ss[7], 8'hBF);
    @(negedge hz100);
    clr = 1'b1;
    set_a(1, 3'd5, 4'd1, 1'b0);
    set_b(1, 3'd6, 4'd2, 1'b0);
    #1;
    chk("clr_a_ready", {7'd0, a_if.ready}, 8'h00);
    chk("clr_b_ready", {7'd0, b_if.ready}, 8'h00);
    @(negedge hz100);
    clr = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (9) @(negedge hz100);
    chk("clr_ss7", ss[7], 8'h00);
    chk("clr_ss5", ss[5], 8'h00);
    chk("clr_ss6", ss[6], 8'h00);
    chk("clr_ss3", ss[3], 8'h00);

    // Divider: SCAN_DIV=3 instance advances one slot every third edge.
    @(negedge hz100);
    rst3 = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge hz100);
      chk($sformatf("div_slot_e%0d", e), {5'd0, scan_slot3}, 8'(e / 3));
    end
    @(negedge hz100);
    @(negedge hz100);
    // Edge 9 is slot 2's terminal count: write slot 2 in that same cycle.
    a3_if.valid = 1; a3_if.idx = 3'd2; a3_if.digit = 4'd3; a3_if.dp = 0;
    #1;
    chk("coll_a_ready", {7'd0, a3_if.ready}, 8'h01);
    chk("coll_slot_pre", {5'd0, scan_slot3}, 8'h02);
    @(negedge hz100);
    a3_if.valid = 0;
    chk("coll_ss2_old", s3[2], 8'h00);
    chk("coll_slot_post", {5'd0, scan_slot3}, 8'h03);
    repeat (23) @(negedge hz100);
    chk("coll_ss2_hold", s3[2], 8'h00);
    chk("coll_slot_revisit", {5'd0, scan_slot3}, 8'h02);
    @(negedge hz100);
    chk("coll_ss2_new", s3[2], 8'h4F);
    chk("coll_slot_next", {5'd0, scan_slot3}, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
